// File: rtl/exe_alu_stage.sv
// Execute-stage ALU with the EXE/MEM pipeline register and the NZCV status
// register. Adds and subtracts share one 33-bit adder. A subtract is formed as
// val1 + ~val2 + carry-in, so bit 32 of the sum is directly the ARM C flag
// (NOT borrow).
module exe_alu_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze,
    input  logic              flush,
    input  logic [3:0]        exe_cmd,
    input  logic              s_bit,
    input  logic [DATA_W-1:0] val1,
    input  logic [DATA_W-1:0] val2,
    input  logic [DATA_W-1:0] val_rm,
    input  logic [3:0]        dest_in,
    input  logic              wb_en_in,
    input  logic              mem_r_in,
    input  logic              mem_w_in,
    output logic [DATA_W-1:0] alu_res,
    output logic [DATA_W-1:0] st_data,
    output logic [3:0]        dest,
    output logic              wb_en,
    output logic              mem_r,
    output logic              mem_w,
    output logic [3:0]        nzcv
);

    typedef enum logic [3:0] {
        OP_MOV = 4'b0001,
        OP_ADD = 4'b0010,
        OP_ADC = 4'b0011,
        OP_SUB = 4'b0100,
        OP_SBC = 4'b0101,
        OP_AND = 4'b0110,
        OP_ORR = 4'b0111,
        OP_EOR = 4'b1000,
        OP_MVN = 4'b1001
    } alu_op_e;

    logic [DATA_W-1:0] alu_res_q, st_data_q;
    logic [3:0]        dest_q;
    logic              wb_en_q, mem_r_q, mem_w_q;
    logic [3:0]        nzcv_q, nzcv_d;

    logic [DATA_W-1:0] res_d;
    logic [DATA_W-1:0] b_op;
    logic              cin;
    logic [DATA_W:0]   sum;
    logic              is_arith, op_valid;
    logic              c_in_q;

    // The carry used by ADC/SBC is the registered flag (value before this update)
    assign c_in_q = nzcv_q[1];

    // Select the adder operands, then choose the result and the next flag value
    always_comb begin
        b_op     = val2;
        cin      = 1'b0;
        is_arith = 1'b0;
        op_valid = 1'b1;
        res_d    = '0;
        nzcv_d   = nzcv_q;

        unique case (exe_cmd)
            OP_ADD: begin b_op = val2;  cin = 1'b0;   is_arith = 1'b1; end
            OP_ADC: begin b_op = val2;  cin = c_in_q; is_arith = 1'b1; end
            OP_SUB: begin b_op = ~val2; cin = 1'b1;   is_arith = 1'b1; end
            OP_SBC: begin b_op = ~val2; cin = c_in_q; is_arith = 1'b1; end
            default: ;
        endcase

        sum = {1'b0, val1} + {1'b0, b_op} + {{DATA_W{1'b0}}, cin};

        unique case (exe_cmd)
            OP_MOV:                         res_d = val2;
            OP_MVN:                         res_d = ~val2;
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: res_d = sum[DATA_W-1:0];
            OP_AND:                         res_d = val1 & val2;
            OP_ORR:                         res_d = val1 | val2;
            OP_EOR:                         res_d = val1 ^ val2;
            default: begin
                res_d    = '0;
                op_valid = 1'b0;
            end
        endcase

        if (s_bit && op_valid && !flush) begin
            nzcv_d[3] = res_d[DATA_W-1];
            nzcv_d[2] = (res_d == '0);
            if (is_arith) begin
                nzcv_d[1] = sum[DATA_W];
                // The adder's operands have the same sign, but the sum's sign differs
                nzcv_d[0] = (val1[DATA_W-1] == b_op[DATA_W-1]) &&
                            (sum[DATA_W-1] != val1[DATA_W-1]);
            end
        end
    end

    // EXE/MEM register. A flush clears the pipe slot even while frozen; nzcv holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_res_q <= '0;
            st_data_q <= '0;
            dest_q    <= '0;
            wb_en_q   <= 1'b0;
            mem_r_q   <= 1'b0;
            mem_w_q   <= 1'b0;
            nzcv_q    <= '0;
        end else if (flush) begin
            alu_res_q <= '0;
            st_data_q <= '0;
            dest_q    <= '0;
            wb_en_q   <= 1'b0;
            mem_r_q   <= 1'b0;
            mem_w_q   <= 1'b0;
        end else if (!freeze) begin
            alu_res_q <= res_d;
            st_data_q <= val_rm;
            dest_q    <= dest_in;
            wb_en_q   <= wb_en_in;
            mem_r_q   <= mem_r_in;
            mem_w_q   <= mem_w_in;
            nzcv_q    <= nzcv_d;
        end
    end

    assign alu_res = alu_res_q;
    assign st_data = st_data_q;
    assign dest    = dest_q;
    assign wb_en   = wb_en_q;
    assign mem_r   = mem_r_q;
    assign mem_w   = mem_w_q;
    assign nzcv    = nzcv_q;

endmodule
